// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with registered status flags and a selectable
// read mode: registered read (FWFT=0) or first-word-fall-through (FWFT=1).
module param_fifo #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              rd_acc;
  logic              wr_acc;

  // A write into a full FIFO is allowed when the head is leaving the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + ONE_C;
      2'b01:   count_nxt = count - ONE_C;
      default: count_nxt = count;
    endcase
  end

  // Storage is never cleared; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (wr_acc && reset)
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE_C;
      if (rd_acc) rd_ptr <= rd_ptr + ONE_C;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_C);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      overflow     <= wr_en & ~wr_acc;
      underflow    <= rd_en & ~rd_acc;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_W-1:0] rd_data_p1;
      logic              vld_p1;

      // Read stage: head entry captured on an accepted read, held otherwise.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
        end else begin
          vld_p1 <= rd_acc;
          if (rd_acc)
            rd_data_p1 <= mem[rd_ptr[ADDR_W-1:0]];
        end
      end

      assign rd_data  = rd_data_p1;
      assign rd_valid = vld_p1;
    end else begin : g_fwft
      // Head is shown combinationally; zero while empty so stale memory stays hidden.
      assign rd_data  = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
      assign rd_valid = ~empty;
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Randomised and directed bench for param_fifo: one registered-read and one
// FWFT instance share stimulus and are checked against a queue model.
module tb_param_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;

  logic [7:0] d0_rd_data, d1_rd_data;
  logic       d0_rd_valid, d1_rd_valid;
  logic       d0_empty, d1_empty, d0_full, d1_full;
  logic       d0_af, d1_af, d0_ae, d1_ae;
  logic [4:0] d0_count, d1_count;
  logic       d0_ovf, d1_ovf, d0_udf, d1_udf;

  param_fifo #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(d0_rd_data), .rd_valid(d0_rd_valid), .empty(d0_empty), .full(d0_full),
    .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
    .overflow(d0_ovf), .underflow(d0_udf)
  );

  param_fifo #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(d1_rd_data), .rd_valid(d1_rd_valid), .empty(d1_empty), .full(d1_full),
    .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
    .overflow(d1_ovf), .underflow(d1_udf)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] q[$];
  logic [7:0] last0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_count0", 32'(d0_count), 32'd0);
    chk("rst_count1", 32'(d1_count), 32'd0);
    chk("rst_empty0", 32'(d0_empty), 32'd1);
    chk("rst_empty1", 32'(d1_empty), 32'd1);
    chk("rst_full0", 32'(d0_full), 32'd0);
    chk("rst_full1", 32'(d1_full), 32'd0);
    chk("rst_ae0", 32'(d0_ae), 32'd1);
    chk("rst_ae1", 32'(d1_ae), 32'd1);
    chk("rst_af0", 32'(d0_af), 32'd0);
    chk("rst_af1", 32'(d1_af), 32'd0);
    chk("rst_rdata0", 32'(d0_rd_data), 32'd0);
    chk("rst_rdata1", 32'(d1_rd_data), 32'd0);
    chk("rst_rvld0", 32'(d0_rd_valid), 32'd0);
    chk("rst_rvld1", 32'(d1_rd_valid), 32'd0);
    chk("rst_ovf0", 32'(d0_ovf), 32'd0);
    chk("rst_ovf1", 32'(d1_ovf), 32'd0);
    chk("rst_udf0", 32'(d0_udf), 32'd0);
    chk("rst_udf1", 32'(d1_udf), 32'd0);
  endtask

  // One clock of stimulus; the model applies the FIFO rules to its queue.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    int         n;
    logic       ra, wa, e_ovf, e_udf;
    logic [7:0] tmp;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    n  = q.size();
    ra = r && (n > 0);
    wa = w && ((n < DEPTH) || ra);
    e_ovf = w && !wa;
    e_udf = r && !ra;
    if (ra) begin
      tmp   = q.pop_front();
      last0 = tmp;
    end
    if (wa) q.push_back(d);
    @(posedge clk);
    #1;
    n = q.size();
    chk("count0", 32'(d0_count), 32'(n));
    chk("count1", 32'(d1_count), 32'(n));
    chk("empty", 32'(d0_empty), 32'(n == 0));
    chk("full", 32'(d0_full), 32'(n == DEPTH));
    chk("almost_full", 32'(d0_af), 32'(n >= AF));
    chk("almost_empty", 32'(d0_ae), 32'(n <= AE));
    chk("overflow", 32'(d0_ovf), 32'(e_ovf));
    chk("underflow", 32'(d0_udf), 32'(e_udf));
    chk("overflow1", 32'(d1_ovf), 32'(e_ovf));
    chk("underflow1", 32'(d1_udf), 32'(e_udf));
    chk("rd_valid0", 32'(d0_rd_valid), 32'(ra));
    chk("rd_data0", 32'(d0_rd_data), 32'(last0));
    chk("rd_valid1", 32'(d1_rd_valid), 32'(n != 0));
    if (n != 0) chk("rd_data1", 32'(d1_rd_data), 32'(q[0]));
  endtask

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;
    last0   = 8'h00;
    #12;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b1;

    // Fill with 0x01..0x10, then one rejected write.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    chk("full_count", 32'(d0_count), 32'd16);
    chk("full_ovf", 32'(d0_ovf), 32'd1);

    // Drain in order, then one rejected read.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain_order", 32'(d0_rd_data), 32'(i));
    end
    step(1'b0, 8'h00, 1'b1);
    chk("drain_udf", 32'(d0_udf), 32'd1);

    // Simultaneous write and read held at full across two pointer wraps.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h80 + i), 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);

    // Write and read together on an empty FIFO.
    step(1'b1, 8'hA5, 1'b1);
    chk("empty_wr_rd_udf", 32'(d0_udf), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("a5_out", 32'(d0_rd_data), 32'hA5);

    // Fall-through presentation of a single word.
    step(1'b1, 8'h3C, 1'b0);
    chk("fwft_data", 32'(d1_rd_data), 32'h3C);
    chk("fwft_valid", 32'(d1_rd_valid), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("fwft_valid_after", 32'(d1_rd_valid), 32'd0);
    chk("fwft_empty_after", 32'(d1_empty), 32'd1);

    // Randomised phases with varying write/read pressure.
    for (int ph = 0; ph < 20; ph++) begin
      int pw, pr;
      pw = int'($urandom_range(10, 90));
      pr = int'($urandom_range(10, 90));
      for (int c = 0; c < 100; c++)
        step(int'($urandom_range(0, 99)) < pw, 8'($urandom), int'($urandom_range(0, 99)) < pr);
    end

    // Reset asserted between edges after five writes.
    step(1'b0, 8'h00, 1'b0);
    while (q.size() != 0) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hD0 + i), 1'b0);
    wr_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals();
    q.delete();
    last0 = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    chk("post_rst_empty", 32'(d0_empty), 32'd1);
    chk("post_rst_count", 32'(d0_count), 32'd0);
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_data", 32'(d0_rd_data), 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
